// File: rtl/div_cmd_sequencer.sv
// Queues dividend/divisor pairs and sequences them one at a time through an external divider,
// holding each result until consumed. Divide-by-zero is answered locally; a hung divider times out.
module div_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       InValid,
   output logic       InReady,
   input  logic [7:0] InDividend,
   input  logic [7:0] InDivisor,
   output logic       Req,
   output logic [7:0] Operand1,
   output logic [7:0] Operand2,
   input  logic       Done,
   input  logic [7:0] Quotient,
   input  logic [7:0] Remainder,
   output logic       OutValid,
   input  logic       OutReady,
   output logic [7:0] OutQuotient,
   output logic [7:0] OutRemainder,
   output logic       OutDivZero,
   output logic       OutTimeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t          state_reg;
   logic [15:0]     fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic [TW-1:0]   tmo_reg;
   logic            done_low_reg;
   logic            req_reg;
   logic [7:0]      op1_reg;
   logic [7:0]      op2_reg;
   logic            out_valid_reg;
   logic [7:0]      out_q_reg;
   logic [7:0]      out_r_reg;
   logic            out_dz_reg;
   logic            out_to_reg;
   logic            push;
   logic            pop;
   logic [15:0]     head;

   assign InReady = (count_reg < (AW+1)'(DEPTH));
   assign push    = InValid & InReady;
   assign pop     = (state_reg == IDLE) && (count_reg != '0) && !out_valid_reg;
   assign head    = fifo_mem[rd_ptr_reg];

   assign Req          = req_reg;
   assign Operand1     = op1_reg;
   assign Operand2     = op2_reg;
   assign OutValid     = out_valid_reg;
   assign OutQuotient  = out_q_reg;
   assign OutRemainder = out_r_reg;
   assign OutDivZero   = out_dz_reg;
   assign OutTimeout   = out_to_reg;

   always_ff @(posedge Clock) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {InDividend, InDivisor};
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_reg     <= IDLE;
         tmo_reg       <= '0;
         done_low_reg  <= 1'b0;
         req_reg       <= 1'b0;
         op1_reg       <= '0;
         op2_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_q_reg     <= '0;
         out_r_reg     <= '0;
         out_dz_reg    <= 1'b0;
         out_to_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  if (head[7:0] == 8'h00) begin
                     out_q_reg     <= 8'hFF;
                     out_r_reg     <= head[15:8];
                     out_dz_reg    <= 1'b1;
                     out_to_reg    <= 1'b0;
                     out_valid_reg <= 1'b1;
                     state_reg     <= HOLD;
                  end else begin
                     op1_reg   <= head[15:8];
                     op2_reg   <= head[7:0];
                     req_reg   <= 1'b1;
                     state_reg <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // Done still high here is the previous operation's level; only a low counts.
               req_reg      <= 1'b0;
               tmo_reg      <= '0;
               done_low_reg <= !Done;
               state_reg    <= WAIT;
            end
            WAIT: begin
               if (done_low_reg && Done) begin
                  out_q_reg     <= Quotient;
                  out_r_reg     <= Remainder;
                  out_dz_reg    <= 1'b0;
                  out_to_reg    <= 1'b0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= HOLD;
               end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                  out_q_reg     <= 8'h00;
                  out_r_reg     <= 8'h00;
                  out_dz_reg    <= 1'b0;
                  out_to_reg    <= 1'b1;
                  out_valid_reg <= 1'b1;
                  state_reg     <= HOLD;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
                  if (!Done)
                     done_low_reg <= 1'b1;
               end
            end
            HOLD: begin
               if (OutReady) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_cmd_sequencer.sv
// Directed bench for div_cmd_sequencer with a behavioural divider whose latency, stale-Done
// hold time and hang behaviour are controlled from the stimulus sequence.
module tb_div_cmd_sequencer;

   logic       Clock = 1'b0;
   logic       nReset;
   logic       InValid;
   logic       InReady;
   logic [7:0] InDividend;
   logic [7:0] InDivisor;
   logic       Req;
   logic [7:0] Operand1;
   logic [7:0] Operand2;
   logic       Done = 1'b0;
   logic [7:0] Quotient = 8'h00;
   logic [7:0] Remainder = 8'h00;
   logic       OutValid;
   logic       OutReady;
   logic [7:0] OutQuotient;
   logic [7:0] OutRemainder;
   logic       OutDivZero;
   logic       OutTimeout;

   int n_assert = 0;
   int n_fail   = 0;

   int   latency   = 10;
   int   stale_cfg = 0;
   bit   hang      = 1'b0;
   int   m_cnt     = 0;
   int   m_stale   = 0;
   bit   m_busy    = 1'b0;
   logic [7:0] m_op1 = 8'h00;
   logic [7:0] m_op2 = 8'h01;

   int   cyc       = 0;
   int   req_cyc   = 0;
   int   req_count = 0;
   logic [7:0] req_op1 = 8'h00;
   logic [7:0] req_op2 = 8'h00;

   div_cmd_sequencer #(.DEPTH(4), .TIMEOUT(32)) dut (
      .Clock        (Clock),
      .nReset       (nReset),
      .InValid      (InValid),
      .InReady      (InReady),
      .InDividend   (InDividend),
      .InDivisor    (InDivisor),
      .Req          (Req),
      .Operand1     (Operand1),
      .Operand2     (Operand2),
      .Done         (Done),
      .Quotient     (Quotient),
      .Remainder    (Remainder),
      .OutValid     (OutValid),
      .OutReady     (OutReady),
      .OutQuotient  (OutQuotient),
      .OutRemainder (OutRemainder),
      .OutDivZero   (OutDivZero),
      .OutTimeout   (OutTimeout)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      cyc++;
      if (Req) begin
         req_cyc = cyc;
         req_count++;
         req_op1 = Operand1;
         req_op2 = Operand2;
      end
   end

   // Divider: Done is a level that stays high until the next Req (optionally stale_cfg cycles longer).
   always @(posedge Clock) begin
      if (Req) begin
         m_op1   <= Operand1;
         m_op2   <= Operand2;
         m_cnt   <= latency;
         m_stale <= stale_cfg;
         m_busy  <= 1'b1;
         if (stale_cfg == 0)
            Done <= 1'b0;
      end else if (m_busy) begin
         if (m_stale > 0) begin
            m_stale <= m_stale - 1;
            if (m_stale == 1)
               Done <= 1'b0;
         end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
         end else if (!hang) begin
            Done      <= 1'b1;
            Quotient  <= m_op1 / m_op2;
            Remainder <= m_op1 % m_op2;
            m_busy    <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
         $display("check %s: observed %0d expected %0d ok", tag, obs, exp);
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      int k = 0;
      @(negedge Clock);
      InValid    = 1'b1;
      InDividend = a;
      InDivisor  = b;
      while (!InReady && k < 200) begin
         @(negedge Clock);
         k++;
      end
      check("push_accept", 32'(InReady), 32'd1);
      @(negedge Clock);
      InValid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!OutValid && k < 200) begin
         @(negedge Clock);
         k++;
      end
      check({tag, "_valid"}, 32'(OutValid), 32'd1);
   endtask

   task automatic expect_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic dz, input logic to);
      wait_valid(tag);
      check({tag, "_quot"}, 32'(OutQuotient), 32'(q));
      check({tag, "_rem"}, 32'(OutRemainder), 32'(r));
      check({tag, "_divzero"}, 32'(OutDivZero), 32'(dz));
      check({tag, "_timeout"}, 32'(OutTimeout), 32'(to));
   endtask

   task automatic ack(input string tag);
      OutReady = 1'b1;
      @(negedge Clock);
      OutReady = 1'b0;
      check({tag, "_ack_clear"}, 32'(OutValid), 32'd0);
   endtask

   initial begin
      int rc;
      int k;
      nReset     = 1'b0;
      InValid    = 1'b0;
      InDividend = 8'h00;
      InDivisor  = 8'h00;
      OutReady   = 1'b0;
      repeat (3) @(negedge Clock);

      check("rst_inready", 32'(InReady), 32'd1);
      check("rst_req", 32'(Req), 32'd0);
      check("rst_outvalid", 32'(OutValid), 32'd0);
      check("rst_operands", {16'd0, Operand1, Operand2}, 32'd0);
      check("rst_result", {16'd0, OutQuotient, OutRemainder}, 32'd0);
      check("rst_flags", {30'd0, OutDivZero, OutTimeout}, 32'd0);
      nReset = 1'b1;
      repeat (2) @(negedge Clock);

      // 9 / 8 through the divider
      push(8'd9, 8'd8);
      expect_result("div9_8", 8'd1, 8'd1, 1'b0, 1'b0);
      check("div9_8_reqs", 32'(req_count), 32'd1);
      check("div9_8_op1", 32'(req_op1), 32'd9);
      check("div9_8_op2", 32'(req_op2), 32'd8);
      repeat (3) @(negedge Clock);
      check("div9_8_hold_valid", 32'(OutValid), 32'd1);
      check("div9_8_hold_quot", 32'(OutQuotient), 32'd1);
      ack("div9_8");

      // divide by zero answered locally
      rc = req_count;
      push(8'd200, 8'd0);
      expect_result("divzero", 8'd255, 8'd200, 1'b1, 1'b0);
      check("divzero_no_req", 32'(req_count), 32'(rc));
      ack("divzero");

      // five commands with the consumer stalled
      push(8'd10, 8'd3);
      push(8'd20, 8'd6);
      push(8'd30, 8'd7);
      push(8'd40, 8'd9);
      push(8'd50, 8'd4);
      check("full_inready", 32'(InReady), 32'd0);
      expect_result("q1", 8'd3, 8'd1, 1'b0, 1'b0);
      check("full_hold_inready", 32'(InReady), 32'd0);
      ack("q1");
      expect_result("q2", 8'd3, 8'd2, 1'b0, 1'b0);
      ack("q2");
      expect_result("q3", 8'd4, 8'd2, 1'b0, 1'b0);
      ack("q3");
      expect_result("q4", 8'd4, 8'd4, 1'b0, 1'b0);
      ack("q4");
      expect_result("q5", 8'd12, 8'd2, 1'b0, 1'b0);
      ack("q5");

      // Done still high from the previous operation for a few cycles after Req
      stale_cfg = 3;
      push(8'd100, 8'd7);
      expect_result("stale", 8'd14, 8'd2, 1'b0, 1'b0);
      ack("stale");
      stale_cfg = 0;

      // divider hangs
      hang = 1'b1;
      push(8'd50, 8'd5);
      expect_result("hang", 8'd0, 8'd0, 1'b0, 1'b1);
      check("hang_cycles", 32'(cyc - req_cyc), 32'd32);
      ack("hang");
      hang = 1'b0;
      push(8'd9, 8'd3);
      expect_result("after_hang", 8'd3, 8'd0, 1'b0, 1'b0);
      ack("after_hang");

      // reset during WAIT with two commands queued
      rc = req_count;
      push(8'd60, 8'd6);
      push(8'd70, 8'd7);
      push(8'd80, 8'd8);
      k = 0;
      while (req_count == rc && k < 100) begin
         @(negedge Clock);
         k++;
      end
      check("mid_req_seen", 32'(req_count), 32'(rc + 1));
      repeat (2) @(negedge Clock);
      check("mid_operand1", 32'(Operand1), 32'd60);
      nReset = 1'b0;
      #1;
      check("mid_rst_inready", 32'(InReady), 32'd1);
      check("mid_rst_req", 32'(Req), 32'd0);
      check("mid_rst_outvalid", 32'(OutValid), 32'd0);
      check("mid_rst_operands", {16'd0, Operand1, Operand2}, 32'd0);
      check("mid_rst_result", {16'd0, OutQuotient, OutRemainder}, 32'd0);
      check("mid_rst_flags", {30'd0, OutDivZero, OutTimeout}, 32'd0);
      @(negedge Clock);
      nReset = 1'b1;
      rc = req_count;
      repeat (20) @(negedge Clock);
      check("post_rst_no_req", 32'(req_count), 32'(rc));
      check("post_rst_inready", 32'(InReady), 32'd1);
      check("post_rst_outvalid", 32'(OutValid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/div_cmd_sequencer.md
DIV_CMD_SEQUENCER -- requirements
Module: div_cmd_sequencer

Interface
REQ-001 Parameters SHALL be DEPTH = 4 (command FIFO entries, power of two) and TIMEOUT = 32 (max cycles from Req to Done).
REQ-002 Clock  in  1  sole clock; all state changes on rising edge.
REQ-003 nReset  in  1  asynchronous, active-low reset.
REQ-004 InValid  in  1  host offers an operand pair.
REQ-005 InReady  out  1  FIFO can accept; transfer when InValid & InReady at a clock edge.
REQ-006 InDividend  in  8  unsigned dividend.
REQ-007 InDivisor  in  8  unsigned divisor.
REQ-008 Req  out  1  start pulse to divider.
REQ-009 Operand1 / Operand2  out  8 each  dividend / divisor to divider.
REQ-010 Done  in  1  divider completion level.
REQ-011 Quotient / Remainder  in  8 each  divider results.
REQ-012 OutValid  out  1  result register holds an unread result.
REQ-013 OutReady  in  1  consumer accepts; transfer when OutValid & OutReady.
REQ-014 OutQuotient / OutRemainder  out  8 each  result data.
REQ-015 OutDivZero / OutTimeout  out  1 each  status flags qualified by OutValid.

Function
REQ-016 Command FIFO SHALL be DEPTH x 16 bits, wrap-around pointers, count 0..DEPTH; InReady = (count < DEPTH).
REQ-017 A simultaneous push and pop on a full FIFO SHALL be refused for push (InReady already 0); on empty, pop never occurs; otherwise both SHALL proceed in one cycle, count unchanged.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-019 IDLE: if FIFO non-empty and OutValid = 0, pop head; divisor 0 -> load result register directly (quotient 8'hFF, remainder = dividend, OutDivZero = 1), go HOLD; else latch head into Operand1/Operand2, go ISSUE.
REQ-020 ISSUE: Req = 1 for exactly one cycle; go WAIT; clear timeout counter.
REQ-021 Operand1/Operand2 SHALL stay stable from ISSUE until leaving WAIT.
REQ-022 WAIT: completion is the first cycle Done = 1 after Done has been sampled 0 at least once since ISSUE (stale Done from the previous operation ignored).
REQ-023 On completion, capture Quotient/Remainder into result register, flags 0, go HOLD.
REQ-024 If TIMEOUT cycles elapse in WAIT without completion: result register = 8'h00/8'h00, OutTimeout = 1, go HOLD.
REQ-025 HOLD: OutValid = 1; on OutReady clear OutValid and go IDLE; result data and flags stable while OutValid & !OutReady.
REQ-026 Throughput: at most one operation in flight; back-to-back commands restart no earlier than the cycle after output transfer.
REQ-027 Req SHALL never be asserted outside ISSUE.

Reset
REQ-028 nReset low SHALL immediately force IDLE, FIFO empty (InReady = 1 after reset), Req = 0, Operand1 = Operand2 = 0, OutValid = 0, OutQuotient = OutRemainder = 0, flags = 0, timeout counter = 0.
REQ-029 Reset mid-operation SHALL discard in-flight and queued commands; no Req pulse on reset release.

Verification
REQ-030 Push (9, 8), divider model returns Done after 10 cycles -> one Req pulse with Operand1 = 9, Operand2 = 8; OutValid with 1 / 1, flags 0.
REQ-031 Push (200, 0) -> no Req; OutValid with 255 / 200, OutDivZero = 1.
REQ-032 Push 5 commands with OutReady = 0 -> first issued, 4 queued, InReady = 0 after fifth accepted... 5th accepted only once first leaves FIFO; results emerge in push order as OutReady is raised.
REQ-033 Divider holds Done = 1 from prior op, push (100, 7) -> result captured only after Done falls and rises again: 14 / 2.
REQ-034 Divider never raises Done -> after 32 WAIT cycles OutValid with 0 / 0, OutTimeout = 1; next command proceeds normally.
REQ-035 Assert nReset during WAIT with 2 queued -> all outputs at reset values; after release no Req and InReady = 1.
